// File: rtl/bm_shared_memory_mc.sv
// Buffer-manager packet memory: one aggregator write port into a shared RAM, NUM_RD_CH dequeue
// channels arbitrated round-robin with per-packet locking onto a single egress stream.
module bm_shared_memory_mc #(
    parameter int unsigned DATA_NBITS    = 512,
    parameter int unsigned VB_NBITS      = 6,
    parameter int unsigned PORT_ID_NBITS = 3,
    parameter int unsigned BUF_PTR_NBITS = 10,
    parameter int unsigned LSB_NBITS     = 2,
    parameter int unsigned NUM_RD_CH     = 4,
    parameter int unsigned RAM_RD_LAT    = 1,
    parameter int unsigned BYPASS_EN     = 1,
    localparam int unsigned CH_NBITS     = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               wr_valid,
    input  logic [BUF_PTR_NBITS-1:0]           wr_buf_ptr,
    input  logic [LSB_NBITS-1:0]               wr_buf_ptr_lsb,
    input  logic [DATA_NBITS-1:0]              wr_data,
    input  logic [NUM_RD_CH-1:0]               rd_req,
    input  logic [NUM_RD_CH*PORT_ID_NBITS-1:0] rd_src_port_id,
    input  logic [NUM_RD_CH*PORT_ID_NBITS-1:0] rd_dst_port_id,
    input  logic [NUM_RD_CH-1:0]               rd_sop,
    input  logic [NUM_RD_CH-1:0]               rd_eop,
    input  logic [NUM_RD_CH*VB_NBITS-1:0]      rd_valid_bytes,
    input  logic [NUM_RD_CH*BUF_PTR_NBITS-1:0] rd_buf_ptr,
    input  logic [NUM_RD_CH*LSB_NBITS-1:0]     rd_buf_ptr_lsb,
    output logic [NUM_RD_CH-1:0]               rd_ack,
    output logic                               rel_buf_valid,
    output logic [PORT_ID_NBITS-1:0]           rel_buf_port_id,
    output logic [BUF_PTR_NBITS-1:0]           rel_buf_ptr,
    output logic                               ed_data_valid,
    output logic [CH_NBITS-1:0]                ed_ch,
    output logic [PORT_ID_NBITS-1:0]           ed_port_id,
    output logic                               ed_sop,
    output logic                               ed_eop,
    output logic [VB_NBITS-1:0]                ed_valid_bytes,
    output logic [DATA_NBITS-1:0]              ed_packet_data
);

    localparam int unsigned ADDR_NBITS = BUF_PTR_NBITS + LSB_NBITS;
    localparam int unsigned DEPTH      = 1 << ADDR_NBITS;

    typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

    typedef struct packed {
        logic [CH_NBITS-1:0]      ch;
        logic [PORT_ID_NBITS-1:0] src;
        logic [PORT_ID_NBITS-1:0] dst;
        logic                     sop;
        logic                     eop;
        logic [VB_NBITS-1:0]      vb;
        logic [BUF_PTR_NBITS-1:0] ptr;
        logic [LSB_NBITS-1:0]     lsb;
    } req_t;

    typedef struct packed {
        logic [CH_NBITS-1:0]      ch;
        logic [PORT_ID_NBITS-1:0] dst;
        logic                     sop;
        logic                     eop;
        logic [VB_NBITS-1:0]      vb;
    } sb_t;

    function automatic logic [CH_NBITS-1:0] rr_idx(input logic [CH_NBITS-1:0] base,
                                                   input int unsigned off);
        return CH_NBITS'((32'(base) + off) % NUM_RD_CH);
    endfunction

    // ---------------- write side ----------------
    logic                  wr_valid_q;
    logic [ADDR_NBITS-1:0] wr_addr_q;
    logic [DATA_NBITS-1:0] wr_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_valid_q <= 1'b0;
        end else begin
            wr_valid_q <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= {wr_buf_ptr, wr_buf_ptr_lsb};
        wr_data_q <= wr_data;
    end

    // ---------------- arbiter ----------------
    arb_state_e          state_q, state_d;
    logic [CH_NBITS-1:0] lock_ch_q, lock_ch_d;
    logic [CH_NBITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_NBITS-1:0] gnt_ch;
    logic                gnt_vld;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_vld   = 1'b0;
        gnt_ch    = '0;
        unique case (state_q)
            StIdle: begin
                for (int unsigned i = 0; i < NUM_RD_CH; i++) begin
                    if (!gnt_vld && rd_req[rr_idx(rr_ptr_q, i)]) begin
                        gnt_vld = 1'b1;
                        gnt_ch  = rr_idx(rr_ptr_q, i);
                    end
                end
            end
            StLocked: begin
                if (rd_req[lock_ch_q]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = lock_ch_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (gnt_vld) begin
            rr_ptr_d = (gnt_ch == CH_NBITS'(NUM_RD_CH - 1)) ? '0 : gnt_ch + 1'b1;
            // Only a genuine packet start locks; mid-packet fragments in idle pass through.
            if (state_q == StIdle && rd_sop[gnt_ch] && !rd_eop[gnt_ch]) begin
                state_d   = StLocked;
                lock_ch_d = gnt_ch;
            end else if (state_q == StLocked && rd_eop[gnt_ch]) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    always_comb begin
        rd_ack = '0;
        if (gnt_vld && rstn) begin
            rd_ack[gnt_ch] = 1'b1;
        end
    end

    req_t gnt_req;

    always_comb begin
        gnt_req = '0;
        for (int unsigned c = 0; c < NUM_RD_CH; c++) begin
            if (gnt_ch == CH_NBITS'(c)) begin
                gnt_req.src = rd_src_port_id[c*PORT_ID_NBITS +: PORT_ID_NBITS];
                gnt_req.dst = rd_dst_port_id[c*PORT_ID_NBITS +: PORT_ID_NBITS];
                gnt_req.sop = rd_sop[c];
                gnt_req.eop = rd_eop[c];
                gnt_req.vb  = rd_valid_bytes[c*VB_NBITS +: VB_NBITS];
                gnt_req.ptr = rd_buf_ptr[c*BUF_PTR_NBITS +: BUF_PTR_NBITS];
                gnt_req.lsb = rd_buf_ptr_lsb[c*LSB_NBITS +: LSB_NBITS];
            end
        end
        gnt_req.ch = gnt_ch;
    end

    // ---------------- read pipeline ----------------
    logic s1_valid_q;
    req_t s1_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= gnt_vld;
        end
    end

    always_ff @(posedge clk) begin
        s1_q <= gnt_req;
    end

    logic [ADDR_NBITS-1:0] rd_addr;
    logic                  byp_hit;
    logic [DATA_NBITS-1:0] mem [DEPTH];

    assign rd_addr = {s1_q.ptr, s1_q.lsb};
    assign byp_hit = (BYPASS_EN != 0) && s1_valid_q && wr_valid_q && (wr_addr_q == rd_addr);

    always_ff @(posedge clk) begin
        if (wr_valid_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    // RAM output, forwarded write data and sideband all travel RAM_RD_LAT stages together.
    logic [DATA_NBITS-1:0] ram_q      [RAM_RD_LAT];
    logic [DATA_NBITS-1:0] byp_data_q [RAM_RD_LAT];
    sb_t                   sb_q       [RAM_RD_LAT];
    logic [RAM_RD_LAT-1:0] sb_valid_q;
    logic [RAM_RD_LAT-1:0] byp_hit_q;

    always_ff @(posedge clk) begin
        ram_q[0]      <= mem[rd_addr];
        byp_data_q[0] <= wr_data_q;
        sb_q[0].ch    <= s1_q.ch;
        sb_q[0].dst   <= s1_q.dst;
        sb_q[0].sop   <= s1_q.sop;
        sb_q[0].eop   <= s1_q.eop;
        sb_q[0].vb    <= s1_q.vb;
        for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
            ram_q[i]      <= ram_q[i-1];
            byp_data_q[i] <= byp_data_q[i-1];
            sb_q[i]       <= sb_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_valid_q <= '0;
            byp_hit_q  <= '0;
        end else begin
            sb_valid_q[0] <= s1_valid_q;
            byp_hit_q[0]  <= byp_hit;
            for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
                sb_valid_q[i] <= sb_valid_q[i-1];
                byp_hit_q[i]  <= byp_hit_q[i-1];
            end
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rel_buf_valid <= 1'b0;
            ed_data_valid <= 1'b0;
        end else begin
            rel_buf_valid <= s1_valid_q && (s1_q.eop || (&s1_q.lsb));
            ed_data_valid <= sb_valid_q[RAM_RD_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        rel_buf_port_id <= s1_q.src;
        rel_buf_ptr     <= s1_q.ptr;
        ed_ch           <= sb_q[RAM_RD_LAT-1].ch;
        ed_port_id      <= sb_q[RAM_RD_LAT-1].dst;
        ed_sop          <= sb_q[RAM_RD_LAT-1].sop;
        ed_eop          <= sb_q[RAM_RD_LAT-1].eop;
        ed_valid_bytes  <= sb_q[RAM_RD_LAT-1].vb;
        ed_packet_data  <= byp_hit_q[RAM_RD_LAT-1] ? byp_data_q[RAM_RD_LAT-1]
                                                   : ram_q[RAM_RD_LAT-1];
    end

endmodule
